// File: rtl/ex_muldiv_stage_pkg.sv
// ex_pkg: op-code map, engine FSM encoding and op classification shared by
// the execute stage and its iterative MUL/DIV engine.
package ex_pkg;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SLT = 4'd5;
   localparam logic [3:0] OP_SLL = 4'd6;
   localparam logic [3:0] OP_SRL = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_DIV = 4'd9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // True for ops that run on the iterative engine and stall the pipeline.
   function automatic logic is_multicycle(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

endpackage

// File: rtl/ex_muldiv_stage_muldiv_iter.sv
// muldiv_iter: iterative unsigned shift-add multiplier / restoring divider.
// One iteration per clock, WIDTH iterations per op, then one DONE cycle.
// MULDIV_HI_EN: when defined the full 2*WIDTH product and the remainder are
// exposed; otherwise the multiplier keeps only the low product word.
module muldiv_iter
   import ex_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic             mode,       // 1 = divide, 0 = multiply
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] product
`ifdef MULDIV_HI_EN
   ,
   output logic [WIDTH-1:0] product_hi,
   output logic [WIDTH-1:0] remainder
`endif
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic             mode_r;
   logic [WIDTH-1:0] a_r;      // multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] b_r;      // multiplicand / divisor
   logic [WIDTH-1:0] acc_r;    // product accumulator / partial remainder

   logic [WIDTH-1:0] a_nx_s;
   logic [WIDTH-1:0] b_nx_s;
   logic [WIDTH-1:0] acc_nx_s;
   logic [WIDTH:0]   rem_sh_s;
   logic [WIDTH-1:0] diff_s;
`ifdef MULDIV_HI_EN
   logic [WIDTH:0]   sum_s;
`else
   logic [WIDTH-1:0] sum_s;
`endif

   // Next-iteration datapath; a zero divisor naturally yields all-ones/dividend.
   always_comb begin
      a_nx_s   = a_r;
      b_nx_s   = b_r;
      acc_nx_s = acc_r;
      rem_sh_s = {acc_r, a_r[WIDTH-1]};
      diff_s   = rem_sh_s[WIDTH-1:0] - b_r;
`ifdef MULDIV_HI_EN
      sum_s    = {1'b0, acc_r} + {1'b0, (a_r[0] ? b_r : {WIDTH{1'b0}})};
`else
      sum_s    = acc_r + (a_r[0] ? b_r : {WIDTH{1'b0}});
`endif
      if (mode_r) begin
         if (rem_sh_s >= {1'b0, b_r}) begin
            acc_nx_s = diff_s;
            a_nx_s   = {a_r[WIDTH-2:0], 1'b1};
         end else begin
            acc_nx_s = rem_sh_s[WIDTH-1:0];
            a_nx_s   = {a_r[WIDTH-2:0], 1'b0};
         end
      end else begin
`ifdef MULDIV_HI_EN
         acc_nx_s = sum_s[WIDTH:1];
         a_nx_s   = {sum_s[0], a_r[WIDTH-1:1]};
`else
         acc_nx_s = sum_s;
         a_nx_s   = {1'b0, a_r[WIDTH-1:1]};
         b_nx_s   = {b_r[WIDTH-2:0], 1'b0};
`endif
      end
   end

   // Engine FSM: latch operands on start, iterate WIDTH times, one DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
         mode_r  <= 1'b0;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         acc_r   <= {WIDTH{1'b0}};
      end else if (flush) begin
         state_r <= IDLE;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  state_r <= BUSY;
                  cnt_r   <= {CNT_W{1'b0}};
                  mode_r  <= mode;
                  a_r     <= op_a;
                  b_r     <= op_b;
                  acc_r   <= {WIDTH{1'b0}};
               end
            end
            BUSY: begin
               a_r   <= a_nx_s;
               b_r   <= b_nx_s;
               acc_r <= acc_nx_s;
               cnt_r <= cnt_r + CNT_W'(1);
               if (cnt_r == CNT_LAST) begin
                  state_r <= DONE;
               end
            end
            DONE:    state_r <= IDLE;
            default: state_r <= IDLE;
         endcase
      end
   end

   assign busy     = (state_r == BUSY);
   assign done     = (state_r == DONE);
   assign quotient = a_r;
`ifdef MULDIV_HI_EN
   assign product    = a_r;
   assign product_hi = acc_r;
   assign remainder  = acc_r;
`else
   assign product    = acc_r;
`endif

endmodule

// File: rtl/ex_muldiv_stage.sv
// ex_muldiv_stage: execute stage with single-cycle ALU and an iterative
// MUL/DIV engine. Freze stalls IF/ID and ID/EX while the engine is busy.
// MULDIV_HI_EN: when defined adds result_hi (high product / remainder).
module ex_muldiv_stage
   import ex_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OP_W  = 4
) (
   input  logic             clk,
   input  logic             rest,
   input  logic             flush,
   input  logic             op_valid,
   input  logic [OP_W-1:0]  alu_op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic [WIDTH-1:0] rd_in,
   output logic             Freze,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] rd_out,
   output logic             result_valid,
   output logic             div_by_zero
`ifdef MULDIV_HI_EN
   ,
   output logic [WIDTH-1:0] result_hi
`endif
);

   logic             eng_busy_s;
   logic             eng_done_s;
   logic             idle_s;
   logic             start_s;
   logic             single_s;
   logic [WIDTH-1:0] quot_s;
   logic [WIDTH-1:0] prod_s;
   logic [WIDTH-1:0] alu_res_s;
   logic [WIDTH-1:0] rd_r;
   logic             div_r;
   logic             dz_r;
`ifdef MULDIV_HI_EN
   logic [WIDTH-1:0] prod_hi_s;
   logic [WIDTH-1:0] rem_s;
`endif

   assign idle_s   = !eng_busy_s && !eng_done_s;
   assign start_s  = rest && op_valid && !flush && idle_s && is_multicycle(alu_op);
   assign single_s = rest && op_valid && !flush && idle_s && !is_multicycle(alu_op);
   // Stall must rise in the same cycle the MUL/DIV is presented.
   assign Freze    = start_s || eng_busy_s;

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv_iter (
      .clk        (clk),
      .rst_n      (rest),
      .start      (start_s),
      .flush      (flush),
      .mode       (alu_op == OP_DIV),
      .op_a       (src_a),
      .op_b       (src_b),
      .busy       (eng_busy_s),
      .done       (eng_done_s),
      .quotient   (quot_s),
      .product    (prod_s)
`ifdef MULDIV_HI_EN
      ,
      .product_hi (prod_hi_s),
      .remainder  (rem_s)
`endif
   );

   // Single-cycle ALU.
   always_comb begin
      alu_res_s = {WIDTH{1'b0}};
      case (alu_op)
         OP_ADD:  alu_res_s = src_a + src_b;
         OP_SUB:  alu_res_s = src_a - src_b;
         OP_AND:  alu_res_s = src_a & src_b;
         OP_OR:   alu_res_s = src_a | src_b;
         OP_XOR:  alu_res_s = src_a ^ src_b;
         OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_SLL:  alu_res_s = src_a << src_b[3:0];
         OP_SRL:  alu_res_s = src_a >> src_b[3:0];
         default: alu_res_s = {WIDTH{1'b0}};
      endcase
   end

   // Remember tag, kind and divide-by-zero of the op handed to the engine.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         rd_r  <= {WIDTH{1'b0}};
         div_r <= 1'b0;
         dz_r  <= 1'b0;
      end else if (start_s) begin
         rd_r  <= rd_in;
         div_r <= (alu_op == OP_DIV);
         dz_r  <= (alu_op == OP_DIV) && (src_b == {WIDTH{1'b0}});
      end
   end

   // Output register: flush squashes, engine completion, else ALU result.
   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         result       <= {WIDTH{1'b0}};
         rd_out       <= {WIDTH{1'b0}};
         result_valid <= 1'b0;
         div_by_zero  <= 1'b0;
`ifdef MULDIV_HI_EN
         result_hi    <= {WIDTH{1'b0}};
`endif
      end else if (flush) begin
         result_valid <= 1'b0;
      end else if (eng_done_s) begin
         result       <= div_r ? quot_s : prod_s;
         rd_out       <= rd_r;
         result_valid <= 1'b1;
         div_by_zero  <= dz_r;
`ifdef MULDIV_HI_EN
         result_hi    <= div_r ? rem_s : prod_hi_s;
`endif
      end else if (single_s) begin
         result       <= alu_res_s;
         rd_out       <= rd_in;
         result_valid <= 1'b1;
         div_by_zero  <= 1'b0;
`ifdef MULDIV_HI_EN
         result_hi    <= {WIDTH{1'b0}};
`endif
      end else begin
         result_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Directed testbench for ex_muldiv_stage (WIDTH=16). Inputs change on the
// falling edge and outputs are sampled 1 time unit later.
module tb_ex_muldiv_stage;

   logic        clk;
   logic        rest;
   logic        flush;
   logic        op_valid;
   logic [3:0]  alu_op;
   logic [15:0] src_a;
   logic [15:0] src_b;
   logic [15:0] rd_in;
   logic        Freze;
   logic [15:0] result;
   logic [15:0] rd_out;
   logic        result_valid;
   logic        div_by_zero;
`ifdef MULDIV_HI_EN
   logic [15:0] result_hi;
`endif

   int n_vec = 0;
   int n_err = 0;
   int fz_cnt;
   int lat;
   int pulses;

   ex_muldiv_stage #(.WIDTH(16), .OP_W(4)) dut (
      .clk          (clk),
      .rest         (rest),
      .flush        (flush),
      .op_valid     (op_valid),
      .alu_op       (alu_op),
      .src_a        (src_a),
      .src_b        (src_b),
      .rd_in        (rd_in),
      .Freze        (Freze),
      .result       (result),
      .rd_out       (rd_out),
      .result_valid (result_valid),
      .div_by_zero  (div_by_zero)
`ifdef MULDIV_HI_EN
      ,
      .result_hi    (result_hi)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one single-cycle op, then check the result one cycle later.
   task automatic single(input string tag, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] rd, input logic [15:0] exp);
      @(negedge clk);
      op_valid = 1'b1; alu_op = op; src_a = a; src_b = b; rd_in = rd;
      #1;
      check({tag, "_freze"}, Freze, 1'b0);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      check({tag, "_result"}, result, exp);
      check({tag, "_valid"}, result_valid, 1'b1);
      check({tag, "_rd"}, rd_out, rd);
   endtask

   // Present a MUL/DIV in cycle 0, hold it while stalled and through DONE;
   // return the number of Freze-high cycles and the result_valid cycle.
   task automatic run_multi(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] rd, output int fz, output int lt);
      logic fz_prev;
      fz = 0;
      lt = -1;
      fz_prev = 1'b1;
      @(negedge clk);
      op_valid = 1'b1; alu_op = op; src_a = a; src_b = b; rd_in = rd;
      #1;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) begin
            @(negedge clk);
            if (!fz_prev) op_valid = 1'b0;
            #1;
         end
         if (Freze) fz++;
         if (result_valid) begin
            lt = c;
            break;
         end
         fz_prev = Freze;
      end
      op_valid = 1'b0;
   endtask

   // Count result_valid pulses over n idle cycles.
   task automatic count_valid(input int n, output int cnt);
      cnt = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         #1;
         if (result_valid) cnt++;
      end
   endtask

   initial begin
      // Reset held with a live ADD presented.
      rest = 1'b0; flush = 1'b0; op_valid = 1'b1;
      alu_op = 4'd0; src_a = 16'd3; src_b = 16'd4; rd_in = 16'h0005;
      repeat (3) @(negedge clk);
      #1;
      check("rst_result", result, 16'h0000);
      check("rst_valid", result_valid, 1'b0);
      check("rst_freze", Freze, 1'b0);
      check("rst_rd", rd_out, 16'h0000);
      check("rst_dz", div_by_zero, 1'b0);
      @(negedge clk);
      rest = 1'b1;
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      check("post_rst_result", result, 16'h0007);
      check("post_rst_valid", result_valid, 1'b1);
      @(negedge clk);
      #1;
      check("hold_result", result, 16'h0007);
      check("hold_valid", result_valid, 1'b0);

      // Back-to-back SUB then SLT.
      @(negedge clk);
      op_valid = 1'b1; alu_op = 4'd1; src_a = 16'h0000; src_b = 16'h0001; rd_in = 16'h0001;
      #1;
      check("b2b_freze0", Freze, 1'b0);
      @(negedge clk);
      alu_op = 4'd5; src_a = 16'hFFFF; src_b = 16'h0001; rd_in = 16'h0002;
      #1;
      check("b2b_sub", result, 16'hFFFF);
      check("b2b_sub_valid", result_valid, 1'b1);
      check("b2b_freze1", Freze, 1'b0);
      @(negedge clk);
      op_valid = 1'b0;
      #1;
      check("b2b_slt", result, 16'h0001);
      check("b2b_slt_valid", result_valid, 1'b1);
      check("b2b_slt_rd", rd_out, 16'h0002);

      // Single-cycle op table.
      single("add_wrap", 4'd0,  16'hFFFF, 16'h0002, 16'h0010, 16'h0001);
      single("and",      4'd2,  16'hF0F0, 16'h3C3C, 16'h0011, 16'h3030);
      single("or",       4'd3,  16'hF000, 16'h000F, 16'h0012, 16'hF00F);
      single("xor",      4'd4,  16'hAAAA, 16'hFFFF, 16'h0013, 16'h5555);
      single("slt_neg",  4'd5,  16'h0001, 16'hFFFF, 16'h0014, 16'h0000);
      single("sll",      4'd6,  16'h0001, 16'h0013, 16'h0015, 16'h0008);
      single("srl",      4'd7,  16'h8000, 16'h0004, 16'h0016, 16'h0800);
      single("op12",     4'd12, 16'h1234, 16'h5678, 16'h0017, 16'h0000);

      // MUL 0x0123 * 0x0010.
      run_multi(4'd8, 16'h0123, 16'h0010, 16'h00A1, fz_cnt, lat);
      check("mul_freze_cycles", fz_cnt, 17);
      check("mul_latency", lat, 18);
      check("mul_result", result, 16'h1230);
      check("mul_rd", rd_out, 16'h00A1);
      check("mul_dz", div_by_zero, 1'b0);
`ifdef MULDIV_HI_EN
      check("mul_hi", result_hi, 16'h0000);
`endif
      @(negedge clk);
      #1;
      check("mul_pulse_end", result_valid, 1'b0);
      check("mul_no_restart", Freze, 1'b0);

      // DIV 100 / 7.
      run_multi(4'd9, 16'h0064, 16'h0007, 16'h00B2, fz_cnt, lat);
      check("div_latency", lat, 18);
      check("div_result", result, 16'h000E);
      check("div_dz", div_by_zero, 1'b0);
`ifdef MULDIV_HI_EN
      check("div_rem", result_hi, 16'h0002);
`endif

      // DIV by zero keeps the same latency.
      run_multi(4'd9, 16'h1234, 16'h0000, 16'h00C3, fz_cnt, lat);
      check("dz_freze_cycles", fz_cnt, 17);
      check("dz_latency", lat, 18);
      check("dz_result", result, 16'hFFFF);
      check("dz_flag", div_by_zero, 1'b1);
`ifdef MULDIV_HI_EN
      check("dz_rem", result_hi, 16'h1234);
`endif
      @(negedge clk);
      #1;
      check("dz_sticky", div_by_zero, 1'b1);

      // Flush in BUSY cycle 5 of a MUL.
      @(negedge clk);
      op_valid = 1'b1; alu_op = 4'd8; src_a = 16'h0003; src_b = 16'h0005; rd_in = 16'h00D4;
      repeat (5) @(negedge clk);
      flush = 1'b1;
      #1;
      check("flush_freze_busy", Freze, 1'b1);
      @(negedge clk);
      flush = 1'b0; op_valid = 1'b0;
      #1;
      check("flush_freze_drop", Freze, 1'b0);
      check("flush_valid", result_valid, 1'b0);
      count_valid(25, pulses);
      check("flush_no_result", pulses, 0);
      single("flush_add", 4'd0, 16'h0001, 16'h0001, 16'h0033, 16'h0002);
      check("add_clears_dz", div_by_zero, 1'b0);

      // Reset in BUSY cycle 9 of a DIV.
      @(negedge clk);
      op_valid = 1'b1; alu_op = 4'd9; src_a = 16'h0050; src_b = 16'h0004; rd_in = 16'h0044;
      repeat (9) @(negedge clk);
      rest = 1'b0;
      #1;
      check("mid_rst_result", result, 16'h0000);
      check("mid_rst_rd", rd_out, 16'h0000);
      check("mid_rst_valid", result_valid, 1'b0);
      check("mid_rst_freze", Freze, 1'b0);
      @(negedge clk);
      rest = 1'b1; op_valid = 1'b0;
      count_valid(25, pulses);
      check("mid_rst_no_result", pulses, 0);
      run_multi(4'd9, 16'h000A, 16'h0003, 16'h0055, fz_cnt, lat);
      check("div10_latency", lat, 18);
      check("div10_freze_cycles", fz_cnt, 17);
      check("div10_result", result, 16'h0003);
      check("div10_rd", rd_out, 16'h0055);
`ifdef MULDIV_HI_EN
      check("div10_rem", result_hi, 16'h0001);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
